shift_cmd_seq: RTL and testbench

//  Command sequencer directly upstream of the 8-bit registered shifter.

---
 rtl/shift_cmd_seq_if.sv | 22 ++
 rtl/shift_cmd_seq.sv | 152 +++++++++++++++
 tb/tb_shift_cmd_seq.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_cmd_seq_if.sv
// Command port of the shift sequencer: valid/ready handshake plus the
// shift command fields.
interface shift_cmd_seq_if #(
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_shamt;
  logic [7:0]       cmd_data;
  logic [CNT_W-1:0] cmd_rpt;

  modport master (
    output cmd_valid, cmd_op, cmd_shamt, cmd_data, cmd_rpt,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_shamt, cmd_data, cmd_rpt,
    output cmd_ready
  );
endinterface

// File: rtl/shift_cmd_seq.sv
// Command sequencer feeding the 8-bit registered shifter: buffers commands
// in a small FIFO and replays each one on op/shamt/d_in for rpt+1 cycles.
module shift_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  shift_cmd_seq_if.slave      cmd,
  output logic [2:0]          op,
  output logic [1:0]          shamt,
  output logic [7:0]          d_in,
  output logic                busy,
  output logic                done,
  output logic [3:0]          level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] OP_NOP = 3'b000;

  typedef struct packed {
    logic [2:0]       op;
    logic [1:0]       shamt;
    logic [7:0]       data;
    logic [CNT_W-1:0] rpt;
  } cmd_t;

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_e;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  state_e           state;
  state_e           state_n;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_n;
  logic [2:0]       op_n;
  logic [1:0]       shamt_n;
  logic [7:0]       d_in_n;
  logic             done_n;

  // Full is judged on the registered level only, so a pop in the same
  // cycle never frees a slot early.
  assign full          = (level == 4'(DEPTH));
  assign empty         = (level == '0);
  assign cmd.cmd_ready = !full;
  assign push          = cmd.cmd_valid && !full;
  assign head          = mem[rd_ptr];
  assign busy          = (state == S_ISSUE);

  // NOTE: storage carries no reset; every entry is written before it is read,
  // and level alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op:    cmd.cmd_op,
                       shamt: cmd.cmd_shamt,
                       data:  cmd.cmd_data,
                       rpt:   cmd.cmd_rpt};
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      rem   <= '0;
      op    <= OP_NOP;
      shamt <= '0;
      d_in  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      op    <= op_n;
      shamt <= shamt_n;
      d_in  <= d_in_n;
      done  <= done_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    op_n    = op;
    shamt_n = shamt;
    d_in_n  = d_in;
    done_n  = 1'b0;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rem != '0) begin
          rem_n = rem - 1'b1;
        end else begin
          done_n = 1'b1;
          if (!empty) begin
            pop = 1'b1;
          end else begin
            op_n    = OP_NOP;
            shamt_n = '0;
            d_in_n  = '0;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A pop always loads the head command, whether from idle or back-to-back.
    if (pop) begin
      op_n    = head.op;
      shamt_n = head.shamt;
      d_in_n  = head.data;
      rem_n   = head.rpt;
    end
  end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed self-checking bench for shift_cmd_seq: reset, single and repeated
// commands, full FIFO, pointer wrap and reset abort.
module tb_shift_cmd_seq;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] LSL  = 3'b010;
  localparam logic [2:0] LSR  = 3'b011;
  localparam logic [2:0] ASR  = 3'b100;

  logic       clk;
  logic       reset_n;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic       busy;
  logic       done;
  logic [3:0] level;

  int n_checks = 0;
  int n_errors = 0;

  shift_cmd_seq_if #(.CNT_W(4)) cmd_if ();

  shift_cmd_seq #(.DEPTH(4), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd     (cmd_if),
    .op      (op),
    .shamt   (shamt),
    .d_in    (d_in),
    .busy    (busy),
    .done    (done),
    .level   (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue log used by the streaming test: every non-NOP op seen at a negedge.
  logic        log_en = 1'b0;
  logic [10:0] log_q[$];
  always @(negedge clk) begin
    if (log_en && op != NOP) log_q.push_back({op, d_in});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Presents a command and holds it until a rising edge accepts it; returns
  // 1 time unit after that edge with cmd_valid still high.
  task automatic push(input logic [2:0] o, input logic [1:0] s,
                      input logic [7:0] d, input logic [3:0] r);
    cmd_if.cmd_op    = o;
    cmd_if.cmd_shamt = s;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_rpt   = r;
    cmd_if.cmd_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (cmd_if.cmd_ready) begin
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("push_timeout", 32'd0, 32'd1);
  endtask

  // Expected trace for the full-FIFO test, one entry per cycle after A ends.
  logic [2:0] t4_op   [8] = '{LSL, LSL, LSR, ASR, ASR, ASR, LOAD, NOP};
  logic [1:0] t4_sh   [8] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
  logic [7:0] t4_d    [8] = '{8'h21, 8'h21, 8'h42, 8'h84, 8'h84, 8'h84, 8'h99, 8'h00};
  logic       t4_done [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       t4_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    bit found;
    logic [2:0] exp_op;

    // T1: reset held with a valid command present.
    reset_n          = 1'b0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = LOAD;
    cmd_if.cmd_shamt = 2'd0;
    cmd_if.cmd_data  = 8'hA5;
    cmd_if.cmd_rpt   = 4'd0;
    repeat (2) @(negedge clk);
    check("t1_op",    32'(op), 32'(NOP));
    check("t1_d_in",  32'(d_in), 32'h0);
    check("t1_level", 32'(level), 32'd0);
    check("t1_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("t1_busy",  32'(busy), 32'd0);
    check("t1_done",  32'(done), 32'd0);

    // Release; the held LOAD A5 is the first push (edge N).
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;

    // T2: single command.
    @(negedge clk);
    check("t2_first_push_level", 32'(level), 32'd1);
    check("t2_op_wait", 32'(op), 32'(NOP));
    @(negedge clk);
    check("t2_op",    32'(op), 32'(LOAD));
    check("t2_d_in",  32'(d_in), 32'hA5);
    check("t2_busy",  32'(busy), 32'd1);
    check("t2_done0", 32'(done), 32'd0);
    check("t2_level", 32'(level), 32'd0);
    @(negedge clk);
    check("t2_op_nop", 32'(op), 32'(NOP));
    check("t2_done",   32'(done), 32'd1);
    check("t2_idle",   32'(busy), 32'd0);
    @(negedge clk);
    check("t2_done_end", 32'(done), 32'd0);

    // T3: LSL by 1, issued 4 times.
    push(LSL, 2'd1, 8'h3C, 4'd3);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("t3_op_wait", 32'(op), 32'(NOP));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t3_op_%0d", i),    32'(op), 32'(LSL));
      check($sformatf("t3_shamt_%0d", i), 32'(shamt), 32'd1);
      check($sformatf("t3_busy_%0d", i),  32'(busy), 32'd1);
      check($sformatf("t3_done_%0d", i),  32'(done), 32'd0);
    end
    @(negedge clk);
    check("t3_op_nop", 32'(op), 32'(NOP));
    check("t3_done",   32'(done), 32'd1);
    @(negedge clk);
    check("t3_done_end", 32'(done), 32'd0);

    // T4: long command A, then fill the FIFO behind it.
    push(LOAD, 2'd0, 8'h11, 4'd15);
    push(LSL,  2'd2, 8'h21, 4'd1);
    push(LSR,  2'd3, 8'h42, 4'd0);
    push(ASR,  2'd1, 8'h84, 4'd2);
    push(LOAD, 2'd0, 8'h99, 4'd0);
    cmd_if.cmd_op   = LSL;
    cmd_if.cmd_data = 8'hEE;
    cmd_if.cmd_rpt  = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_full_level_%0d", i), 32'(level), 32'd4);
      check($sformatf("t4_full_ready_%0d", i), 32'(cmd_if.cmd_ready), 32'd0);
      check($sformatf("t4_a_op_%0d", i), 32'(d_in), 32'h11);
    end
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (d_in != 8'h11) found = 1'b1;
    end
    check("t4_b_start", 32'(found), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      check($sformatf("t4_op_%0d", i),    32'(op), 32'(t4_op[i]));
      check($sformatf("t4_shamt_%0d", i), 32'(shamt), 32'(t4_sh[i]));
      check($sformatf("t4_d_in_%0d", i),  32'(d_in), 32'(t4_d[i]));
      check($sformatf("t4_done_%0d", i),  32'(done), 32'(t4_done[i]));
      check($sformatf("t4_busy_%0d", i),  32'(busy), 32'(t4_busy[i]));
    end
    @(negedge clk);
    check("t4_no_fifth", 32'(op), 32'(NOP));
    check("t4_level_end", 32'(level), 32'd0);

    // T5: stream 10 commands with cmd_valid held high.
    log_q.delete();
    log_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_op = 3'((i % 4) + 1);
      push(exp_op, 2'd0, 8'(8'h10 + i), 4'd0);
    end
    cmd_if.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    log_en = 1'b0;
    check("t5_count", 32'(log_q.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      exp_op = 3'((i % 4) + 1);
      check($sformatf("t5_cmd_%0d", i), 32'(log_q[i]), 32'({exp_op, 8'(8'h10 + i)}));
    end
    check("t5_level", 32'(level), 32'd0);
    check("t5_idle",  32'(busy), 32'd0);

    // T6: reset in the middle of a long command with two queued behind it.
    push(LOAD, 2'd0, 8'h5A, 4'd15);
    push(LSR,  2'd1, 8'h66, 4'd0);
    push(ASR,  2'd2, 8'h77, 4'd0);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    check("t6_busy",  32'(busy), 32'd1);
    check("t6_level", 32'(level), 32'd2);
    check("t6_op",    32'(op), 32'(LOAD));
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_abort_op",    32'(op), 32'(NOP));
    check("t6_abort_d_in",  32'(d_in), 32'h0);
    check("t6_abort_busy",  32'(busy), 32'd0);
    check("t6_abort_level", 32'(level), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t6_post_done_%0d", i),  32'(done), 32'd0);
      check($sformatf("t6_post_op_%0d", i),    32'(op), 32'(NOP));
      check($sformatf("t6_post_level_%0d", i), 32'(level), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
